// File: rtl/fides_sbox_sched.sv
// fides_sbox_sched: streams a 4-share Fides state one 5-bit chunk per cycle
// through a single shared external S-box and gathers the shared results.
module fides_sbox_sched #(
  parameter int NCHUNK = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  hold,
  input  logic [5*NCHUNK-1:0]   st_in_s0,
  input  logic [5*NCHUNK-1:0]   st_in_s1,
  input  logic [5*NCHUNK-1:0]   st_in_s2,
  input  logic [5*NCHUNK-1:0]   st_in_s3,
  output logic [4:0]            sb_a0,
  output logic [4:0]            sb_a1,
  output logic [4:0]            sb_a2,
  output logic [4:0]            sb_a3,
  input  logic [4:0]            sb_y0,
  input  logic [4:0]            sb_y1,
  input  logic [4:0]            sb_y2,
  input  logic [4:0]            sb_y3,
  output logic [5*NCHUNK-1:0]   st_out_s0,
  output logic [5*NCHUNK-1:0]   st_out_s1,
  output logic [5*NCHUNK-1:0]   st_out_s2,
  output logic [5*NCHUNK-1:0]   st_out_s3,
  output logic                  busy,
  output logic                  done
);
  localparam int W  = 5 * NCHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, nxt;
  logic [W-1:0] in_s0, in_s1, in_s2, in_s3;
  logic load, step, last;
  always_comb begin
    load     = (state == IDLE) && start;
    step     = (state == RUN) && !hold;
    last     = (cnt == CW'(NCHUNK - 1));
    nxt      = cnt + CW'(1);
    state_nx = load ? RUN : (step && last) ? IDLE : state;
  end
  assign busy = (state == RUN);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  // Each share stays on its own path end to end; no two shares ever meet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      done      <= 1'b0;
      sb_a0     <= '0;
      sb_a1     <= '0;
      sb_a2     <= '0;
      sb_a3     <= '0;
      in_s0     <= '0;
      in_s1     <= '0;
      in_s2     <= '0;
      in_s3     <= '0;
      st_out_s0 <= '0;
      st_out_s1 <= '0;
      st_out_s2 <= '0;
      st_out_s3 <= '0;
    end else begin
      done <= step && last;
      if (load) begin
        in_s0 <= st_in_s0;
        in_s1 <= st_in_s1;
        in_s2 <= st_in_s2;
        in_s3 <= st_in_s3;
        sb_a0 <= st_in_s0[4:0];
        sb_a1 <= st_in_s1[4:0];
        sb_a2 <= st_in_s2[4:0];
        sb_a3 <= st_in_s3[4:0];
        cnt   <= '0;
      end else if (step) begin
        st_out_s0[5*cnt +: 5] <= sb_y0;
        st_out_s1[5*cnt +: 5] <= sb_y1;
        st_out_s2[5*cnt +: 5] <= sb_y2;
        st_out_s3[5*cnt +: 5] <= sb_y3;
        cnt   <= last ? cnt : nxt;
        sb_a0 <= last ? 5'd0 : in_s0[5*nxt +: 5];
        sb_a1 <= last ? 5'd0 : in_s1[5*nxt +: 5];
        sb_a2 <= last ? 5'd0 : in_s2[5*nxt +: 5];
        sb_a3 <= last ? 5'd0 : in_s3[5*nxt +: 5];
      end
    end
  end
endmodule
